// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter draining a first-word-fall-through TX FIFO
//
// Serialises one FIFO word per frame: start bit, DBIT data bits LSB first,
// optional parity bit, then a stop period of SB_TICK baud ticks.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   s_tick        16x oversampling baud enable, one clk wide
//   fifo_empty    TX FIFO empty flag
//   fifo_rd_data  FIFO head word, valid while fifo_empty=0
//   fifo_rd       pop strobe, high for the IDLE cycle that captures the head word
//   tx            serial line, idle high, driven from a flop
//   tx_busy       high whenever the transmitter is not IDLE
//   tx_done_tick  high for the cycle carrying the final stop-period tick
module uart_tx_fifo #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rd_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [5:0] BIT_LAST  = 6'd15;
  localparam logic [5:0] STOP_LAST = 6'(SB_TICK - 1);
  localparam logic [2:0] DBIT_LAST = 3'(DBIT - 1);
  localparam logic       ODD_BIT   = (PARITY_ODD != 0);
  localparam logic       PAR_ON    = (PARITY_EN != 0);

  state_t          state_q, state_d;
  logic [5:0]      tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            pop_c;
  logic            done_c;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop_c    = 1'b0;
    done_c   = 1'b0;

    case (state_q)
      IDLE: begin
        // Head word is captured on the same edge that pops it.
        if (!fifo_empty) begin
          pop_c    = 1'b1;
          shift_d  = fifo_rd_data;
          tick_d   = '0;
          parity_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d   = '0;
            shift_d  = shift_q >> 1;
            parity_d = parity_q ^ shift_q[0];
            if (bit_q == DBIT_LAST) begin
              state_d = PAR_ON ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = '0;
            done_c  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so the flopped tx changes
  // on the same edge as the state it belongs to.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d ^ ODD_BIT;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  // Gated by reset_n so a populated FIFO is never popped while held in reset.
  assign fifo_rd      = pop_c & reset_n;
  assign tx_done_tick = done_c;
  assign tx           = tx_q;
  assign tx_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [3:0] s_tick;
  logic [3:0] fifo_empty;
  logic [7:0] rd_data [4];
  logic [3:0] fifo_rd;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;

  int n_cmp;
  int n_err;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2 (SB_TICK=32)
  uart_tx_fifo #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
    .clk(clk), .reset_n(rst_n), .s_tick(s_tick[0]), .fifo_empty(fifo_empty[0]),
    .fifo_rd_data(rd_data[0]), .fifo_rd(fifo_rd[0]), .tx(tx[0]),
    .tx_busy(busy[0]), .tx_done_tick(done[0]));
  uart_tx_fifo #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
    .clk(clk), .reset_n(rst_n), .s_tick(s_tick[1]), .fifo_empty(fifo_empty[1]),
    .fifo_rd_data(rd_data[1]), .fifo_rd(fifo_rd[1]), .tx(tx[1]),
    .tx_busy(busy[1]), .tx_done_tick(done[1]));
  uart_tx_fifo #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
    .clk(clk), .reset_n(rst_n), .s_tick(s_tick[2]), .fifo_empty(fifo_empty[2]),
    .fifo_rd_data(rd_data[2]), .fifo_rd(fifo_rd[2]), .tx(tx[2]),
    .tx_busy(busy[2]), .tx_done_tick(done[2]));
  uart_tx_fifo #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_8n2 (
    .clk(clk), .reset_n(rst_n), .s_tick(s_tick[3]), .fifo_empty(fifo_empty[3]),
    .fifo_rd_data(rd_data[3]), .fifo_rd(fifo_rd[3]), .tx(tx[3]),
    .tx_busy(busy[3]), .tx_done_tick(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         div;      // clk per s_tick
    int         nper;     // bit periods to check, start..first stop period
    logic [11:0] line;    // expected level per bit period, bit 0 = start
    int         len;      // clk from pop to tx_done_tick inclusive
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int  i;
    int  done_k;
    int  extra_rd;
    int  not_busy;
    int  per;
    logic line [1:800];
    i = v.inst;
    done_k = -1;
    extra_rd = 0;
    not_busy = 0;
    per = 16 * v.div;
    @(posedge clk); #1;
    rd_data[i] = v.data; fifo_empty[i] = 1'b0; s_tick[i] = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d pop", vi), fifo_rd[i], 1'b1);
    @(posedge clk); #1;
    // Later FIFO activity must not disturb the frame in flight.
    fifo_empty[i] = 1'b1; rd_data[i] = ~v.data; s_tick[i] = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      line[k] = tx[i];
      if (fifo_rd[i]) extra_rd++;
      if (!busy[i]) not_busy++;
      if (done[i]) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
      s_tick[i] = ((k % v.div) == 0);
    end
    chk($sformatf("v%0d frame_len", vi), done_k, v.len);
    chk($sformatf("v%0d extra_rd", vi), extra_rd, 0);
    chk($sformatf("v%0d busy_gap", vi), not_busy, 0);
    if (done_k > 0) begin
      for (int b = 0; b < v.nper; b++) begin
        chk($sformatf("v%0d bit%0d", vi, b), line[per * b + per / 2], v.line[b]);
      end
    end
    @(posedge clk); #1;
    s_tick[i] = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d idle_after", vi), {busy[i], tx[i]}, 2'b01);
  endtask

  vec_t vecs [8];

  initial begin
    logic [7:0] q [$];
    logic       txl [0:399];
    logic       rdl [0:399];
    logic       dnl [0:399];
    int         p1, p2, d1, nrd, ndn, bad_idle, rst_rd, done_seen;
    logic [7:0] b1, b2;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    s_tick = 4'hF;
    fifo_empty = 4'hF;
    for (int i = 0; i < 4; i++) rd_data[i] = 8'h00;

    vecs[0] = '{0, 8'h55, 1, 10, 12'h2AA, 160};
    vecs[1] = '{0, 8'h00, 1, 10, 12'h200, 160};
    vecs[2] = '{0, 8'hFF, 1, 10, 12'h3FE, 160};
    vecs[3] = '{1, 8'h07, 1, 11, 12'h60E, 176};
    vecs[4] = '{2, 8'h07, 1, 11, 12'h40E, 176};
    vecs[5] = '{1, 8'h00, 1, 11, 12'h400, 176};
    vecs[6] = '{3, 8'hFF, 4, 10, 12'h3FE, 701};
    vecs[7] = '{3, 8'hA5, 1, 10, 12'h34A, 176};

    // Reset state, then a long empty stretch with ticks every clk.
    repeat (3) @(negedge clk);
    chk("reset tx", tx, 4'hF);
    chk("reset busy", busy, 4'h0);
    chk("reset rd", fifo_rd, 4'h0);
    chk("reset done", done, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad_idle = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (tx !== 4'hF || fifo_rd !== 4'h0 || busy !== 4'h0 || done !== 4'h0) bad_idle++;
    end
    chk("empty idle", bad_idle, 0);

    for (int v = 0; v < 8; v++) run_vec(v, vecs[v]);

    // Back-to-back frames from a two-entry FIFO.
    q.push_back(8'hA5);
    q.push_back(8'h3C);
    @(posedge clk); #1;
    s_tick[0] = 1'b1;
    fifo_empty[0] = (q.size() == 0);
    rd_data[0] = (q.size() != 0) ? q[0] : 8'h00;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      txl[c] = tx[0]; rdl[c] = fifo_rd[0]; dnl[c] = done[0];
      @(posedge clk); #1;
      if (rdl[c] && q.size() != 0) void'(q.pop_front());
      fifo_empty[0] = (q.size() == 0);
      rd_data[0] = (q.size() != 0) ? q[0] : 8'h00;
    end
    p1 = -1; p2 = -1; d1 = -1; nrd = 0; ndn = 0;
    for (int c = 0; c < 400; c++) begin
      if (rdl[c]) begin
        nrd++;
        if (p1 < 0) p1 = c; else if (p2 < 0) p2 = c;
      end
      if (dnl[c]) begin
        ndn++;
        if (d1 < 0) d1 = c;
      end
    end
    chk("b2b rd_count", nrd, 2);
    chk("b2b done_count", ndn, 2);
    chk("b2b first_done", d1, 160);
    chk("b2b rd_after_done", p2, d1 + 1);
    b1 = 8'h00; b2 = 8'h00;
    if (p1 >= 0 && p2 >= 0 && p2 < 250) begin
      for (int b = 0; b < 8; b++) begin
        b1[b] = txl[p1 + 16 * (b + 1) + 8];
        b2[b] = txl[p2 + 16 * (b + 1) + 8];
      end
    end
    chk("b2b byte1", b1, 8'hA5);
    chk("b2b byte2", b2, 8'h3C);

    // Reset in the middle of data bit 3, with a new word already waiting.
    @(posedge clk); #1;
    rd_data[0] = 8'h00; fifo_empty[0] = 1'b0;
    @(negedge clk);
    chk("mid pop", fifo_rd[0], 1'b1);
    @(posedge clk); #1;
    fifo_empty[0] = 1'b1;
    repeat (69) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid pre_reset", {busy[0], tx[0]}, 2'b10);
    @(posedge clk); #1;
    rd_data[0] = 8'h81; fifo_empty[0] = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid reset_tx_busy", {busy[0], tx[0]}, 2'b01);
    rst_rd = 0;
    repeat (3) begin
      @(negedge clk);
      if (fifo_rd[0]) rst_rd++;
    end
    chk("mid rd_in_reset", rst_rd, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid fresh_pop", fifo_rd[0], 1'b1);
    @(posedge clk); #1;
    fifo_empty[0] = 1'b1;
    @(negedge clk);
    chk("mid fresh_start", {busy[0], tx[0]}, 2'b10);
    done_seen = 0;
    for (int c = 0; c < 300 && done_seen == 0; c++) begin
      @(negedge clk);
      if (done[0]) done_seen = 1;
    end
    chk("mid fresh_done", done_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter that drains the TX FIFO and serialises each byte onto the line.
- Sits directly downstream of the TX FIFO: reads the FIFO's head word and generates the FIFO read strobe that advances its read pointer.
- Frame timing is driven by the shared 16x-oversampling baud tick from the baud-rate generator.
- Frame format: start bit, DBIT data bits LSB first, optional parity bit, stop period.

Parameters:
- DBIT, 8, number of data bits per frame (5..8).
- SB_TICK, 16, stop-period length in s_ticks (16 = 1 stop, 24 = 1.5, 32 = 2).
- PARITY_EN, 0, 1 = insert parity bit after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_tick  input  1  one-clk-wide enable, 16 per bit period, synchronous to clk.
- fifo_empty  input  1  TX FIFO empty flag.
- fifo_rd_data  input  DBIT  FIFO head word; valid whenever fifo_empty=0 (first-word-fall-through).
- fifo_rd  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line, idle high, registered.
- tx_busy  output  1  high in any state other than IDLE.
- tx_done_tick  output  1  one-cycle pulse at the end of the stop period.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0, tick counter=0, bit counter=0, shift register=0.
- Reset asserted mid-frame: tx returns to 1 immediately, the frame is abandoned, and no fifo_rd is issued. The abandoned byte stays popped.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If fifo_empty=0: in the same cycle, assert fifo_rd for exactly one clk, load fifo_rd_data into the shift register, clear the tick counter, and go to START next cycle.
  - s_tick is ignored in IDLE.
- START: tx=0. On each s_tick the counter increments; on the s_tick with counter=15, clear the counter, clear the bit counter, and go to DATA.
- DATA:
  - tx = shift register bit 0.
  - On the s_tick with counter=15: shift right by one and increment the bit counter.
  - On the bit with bit counter=DBIT-1: go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - Parity accumulates as XOR of the transmitted data bits.
- PARITY: tx = XOR(data) XOR PARITY_ODD. Lasts 16 s_ticks, then go to STOP.
- STOP:
  - tx=1 for SB_TICK s_ticks.
  - On the s_tick with counter=SB_TICK-1: pulse tx_done_tick for one cycle and go to IDLE.
- Tick counter width: 6 bits, wide enough for SB_TICK up to 32. Bit counter width: 3 bits.
- Back-to-back frames: if the FIFO is non-empty on return to IDLE, the next fifo_rd occurs in that first IDLE cycle. The line shows no extra idle bit beyond the stop period.
- fifo_rd is never asserted while fifo_empty=1, and at most once per frame.
- FIFO activity after the pop (fifo_empty or fifo_rd_data changing) has no effect on the frame in flight.
- s_tick exactly at the state-entry cycle:
  - Entry into START is the cycle after fifo_rd, so the start bit lasts 16 ticks counted from the first s_tick after entry.
  - A tick that coincides with a state transition counts toward the state being exited.
- tx is driven from a flop: no combinational glitches on the line.

Test Plan:
- Reset/empty: reset_n low for 3 clk, then fifo_empty=1 held for 1000 clk with s_tick every clk -> tx=1, fifo_rd never asserted, tx_busy=0.
- Single frame 8N1: FIFO holds 0x55, s_tick every clk.
  - Expect one fifo_rd pulse, then tx = 0 for 16 clk.
  - Then data bits 1,0,1,0,1,0,1,0, each for 16 clk.
  - Then 1 for 16 clk, then tx_done_tick for 1 clk. Total 160 ticks.
- Back-to-back: FIFO holds 0xA5 then 0x3C, s_tick every clk.
  - Expect the second fifo_rd exactly 1 clk after the first tx_done_tick.
  - Decoded bytes 0xA5, 0x3C. Exactly 2 fifo_rd pulses.
- Parity: PARITY_EN=1, PARITY_ODD=0, data 0x07 -> parity bit=1. PARITY_ODD=1, data 0x07 -> parity bit=0. Frame length 176 ticks.
- Stop length: SB_TICK=32, s_tick every 4 clk, data 0xFF -> stop period high for 128 clk before tx_done_tick.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 of 0x00 -> tx=1 within the same cycle, state IDLE, tx_busy=0. After release with the FIFO non-empty -> a fresh frame starts with a new fifo_rd.
